// File: rtl/counter_8bit.sv
// Up/down counter with a programmable inclusive wrap limit, hold control and
// asynchronous active-low clear. The single count register drives the output.
module counter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             direction,
  input  logic [WIDTH-1:0] maxium,
  input  logic             pause,
  output logic [WIDTH-1:0] counter
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state rule: pause holds, up wraps on the >= compare (never on
  // arithmetic overflow), down wraps from 0 and clamps to a lowered limit.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (!pause) begin
      if (direction) begin
        if (count_q >= maxium) count_d = ZERO;
        else                   count_d = count_q + ONE;
      end else begin
        if (count_q == ZERO)       count_d = maxium;
        else if (count_q > maxium) count_d = maxium;
        else                       count_d = count_q - ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the clear is in the
  // sensitivity list so it acts without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= ZERO;
    else      count_q <= count_d;
  end

  assign counter = count_q;

endmodule

// File: tb/tb_counter_8bit.sv
// Scoreboard bench for counter_8bit: the driver pushes reference-model
// predictions into a queue, and a monitor pops one and compares after each rising edge.
module tb_counter_8bit;

  logic       clk;
  logic       rst;
  logic       direction;
  logic [7:0] maxium;
  logic       pause;
  logic [7:0] counter;

  int tests_run = 0;
  int tests_failed = 0;
  int model_cnt = 0;
  int exp_q[$];

  counter_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .direction (direction),
    .maxium    (maxium),
    .pause     (pause),
    .counter   (counter)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input int exp);
    tests_run++;
    if ($isunknown(act) || int'(act) != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules stated on plain integers, one call per rising edge.
  function automatic int model_next(input int c, input bit r, input bit d,
                                    input int m, input bit p);
    if (!r) return 0;
    if (p) return c;
    if (d) return (c >= m) ? 0 : c + 1;
    if (c == 0) return m;
    if (c > m) return m;
    return c - 1;
  endfunction

  // Drive inputs for the next rising edge and queue the predicted result.
  task automatic step(input bit r, input bit d, input int m, input bit p);
    @(negedge clk);
    rst       = r;
    direction = d;
    maxium    = 8'(m);
    pause     = p;
    model_cnt = model_next(model_cnt, r, d, m, p);
    exp_q.push_back(model_cnt);
  endtask

  task automatic run(input int n, input bit d, input int m, input bit p);
    for (int i = 0; i < n; i++) step(1'b1, d, m, p);
  endtask

  // Clear between edges; the output must drop before the next rising edge.
  task automatic async_reset(input bit p);
    @(negedge clk);
    #2;
    pause = p;
    rst   = 1'b0;
    #1;
    check("async_clear", counter, 0);
    model_cnt = 0;
    exp_q.push_back(0);
  endtask

  // Monitor: the counter presents a new value after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("counter", counter, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; direction = 1'b1; maxium = 8'd5; pause = 1'b0;
    #1 rst = 1'b0;
    #1 check("reset_state", counter, 0);

    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b1, 5, 1'b0);

    run(7, 1'b1, 5, 1'b0);     // 1,2,3,4,5,0,1
    run(2, 1'b1, 5, 1'b0);     // 2,3
    run(13, 1'b1, 15, 1'b0);   // raised limit: 4..15,0
    run(12, 1'b1, 15, 1'b0);   // 1..12
    run(1, 1'b1, 7, 1'b0);     // lowered limit in up mode: 0
    run(12, 1'b1, 15, 1'b0);   // back to 12
    run(2, 1'b0, 7, 1'b0);     // clamp then count down: 7,6
    run(3, 1'b1, 15, 1'b0);    // 7,8,9
    run(5, 1'b1, 15, 1'b1);    // hold at 9
    run(5, 1'b1, 15, 1'b0);    // 10..14

    async_reset(1'b1);         // clear wins over pause
    step(1'b0, 1'b1, 15, 1'b1);
    step(1'b0, 1'b0, 15, 1'b0);

    run(34, 1'b0, 32, 1'b0);   // 32,31,..,0,32
    run(12, 1'b0, 32, 1'b0);   // down to 20
    run(5, 1'b1, 32, 1'b0);    // 21..25

    run(3, 1'b1, 0, 1'b0);     // limit 0 pins the count at 0
    run(3, 1'b0, 0, 1'b0);

    run(1, 1'b0, 255, 1'b0);   // 0 -> 255
    run(1, 1'b1, 255, 1'b0);   // 255 -> 0 via the compare
    run(3, 1'b0, 255, 1'b0);   // 255,254,253

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset(1'($urandom_range(0, 1)));
      end else begin
        int lim;
        lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 20));
        step(1'b1, 1'($urandom_range(0, 1)), lim, ($urandom_range(0, 4) == 0));
      end
    end

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
